// File: rtl/dlfloat16_pkg.sv
// Shared constants and state type for the DLFLOAT16 issue controller.
package dlfloat16_pkg;

  localparam logic [6:0] OPC_FP  = 7'b1010011;
  localparam logic [4:0] F5_DIV  = 5'b00011;
  localparam logic [4:0] F5_SQRT = 5'b01011;

  // Flag bit positions, {invalid, div_by_zero, overflow, underflow, inexact}
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [4:0] EXC_ILLEGAL = 5'b00001 << FLAG_NV;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

endpackage

// File: rtl/dlfloat16_lat_cnt.sv
// Latency down-counter: load a value, decrement towards zero, report zero.
module dlfloat16_lat_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dlfloat16_issue_ctrl.sv
// Single-outstanding FPU issue controller with per-op fixed latency.
// Optional sticky fflags register enabled by DLFLOAT16_FFLAGS_EN.
module dlfloat16_issue_ctrl
  import dlfloat16_pkg::*;
#(
  parameter int unsigned FIXED_LAT = 1,
  parameter int unsigned DIV_LAT   = 8,
  parameter int unsigned SQRT_LAT  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  input  logic [31:0] in_op3,
  output logic [31:0] fpu_instr,
  output logic [31:0] fpu_op1,
  output logic [31:0] fpu_op2,
  output logic [31:0] fpu_op3,
  output logic        fpu_start,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_excep,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_excep,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        busy
);

  state_t     state, state_nxt;
  logic       accept, legal, cnt_zero, done, hs;
  logic [3:0] lat_sel;

  assign accept    = in_valid && in_ready;
  assign legal     = (in_instr[6:0] == OPC_FP);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign done      = (state == EXEC) && cnt_zero;
  assign hs        = out_valid && out_ready;

  always_comb begin
    lat_sel = 4'(FIXED_LAT);
    if (in_instr[31:27] == F5_DIV) begin
      lat_sel = 4'(DIV_LAT);
    end else if (in_instr[31:27] == F5_SQRT) begin
      lat_sel = 4'(SQRT_LAT);
    end
  end

  // Capture happens on the edge that observes a zero count, giving LAT+1 edges.
  dlfloat16_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && legal),
    .load_val (lat_sel),
    .dec      (state == EXEC),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = legal ? EXEC : RESP;
      EXEC: if (cnt_zero) state_nxt = RESP;
      RESP: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_instr  <= '0;
      fpu_op1    <= '0;
      fpu_op2    <= '0;
      fpu_op3    <= '0;
      fpu_start  <= 1'b0;
      out_result <= '0;
      out_excep  <= '0;
    end else begin
      fpu_start <= 1'b0;
      if (accept) begin
        fpu_instr <= in_instr;
        fpu_op1   <= in_op1;
        fpu_op2   <= in_op2;
        fpu_op3   <= in_op3;
        fpu_start <= legal;
        if (!legal) begin
          out_result <= '0;
          out_excep  <= EXC_ILLEGAL;
        end
      end else if (done) begin
        out_result <= fpu_result;
        out_excep  <= fpu_excep;
      end
    end
  end

`ifdef DLFLOAT16_FFLAGS_EN
  logic [4:0] fflags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_q <= '0;
    end else if (hs) begin
      fflags_q <= (fflags_clr ? 5'b0 : fflags_q) | out_excep;
    end else if (fflags_clr) begin
      fflags_q <= '0;
    end
  end

  assign fflags = fflags_q;
`else
  logic unused_fflags_clr;
  logic unused_hs;

  assign unused_fflags_clr = fflags_clr;
  assign unused_hs         = hs;
  assign fflags            = '0;
`endif

endmodule

// File: tb/tb_dlfloat16_issue_ctrl.sv
// Self-checking bench for dlfloat16_issue_ctrl against a transaction-level model.
module tb_dlfloat16_issue_ctrl;

  localparam int unsigned FL = 1;
  localparam int unsigned DL = 8;
  localparam int unsigned SL = 5;
  localparam logic [6:0]  OPC = 7'b1010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_op1, in_op2, in_op3;
  logic [31:0] fpu_instr, fpu_op1, fpu_op2, fpu_op3;
  logic        fpu_start;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_excep;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_excep;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        busy;

  int unsigned npass  = 0;
  int unsigned ntotal = 0;
  int unsigned nfail  = 0;
  logic [4:0]  m_ff   = 5'b0;

  always #5 clk = ~clk;

  dlfloat16_issue_ctrl #(
    .FIXED_LAT (FL),
    .DIV_LAT   (DL),
    .SQRT_LAT  (SL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .in_op3     (in_op3),
    .fpu_instr  (fpu_instr),
    .fpu_op1    (fpu_op1),
    .fpu_op2    (fpu_op2),
    .fpu_op3    (fpu_op3),
    .fpu_start  (fpu_start),
    .fpu_result (fpu_result),
    .fpu_excep  (fpu_excep),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_excep  (out_excep),
    .fflags     (fflags),
    .fflags_clr (fflags_clr),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int unsigned exp_lat(input logic [31:0] ins);
    if (ins[31:27] == 5'b00011) return DL;
    if (ins[31:27] == 5'b01011) return SL;
    return FL;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] f5, input logic [6:0] opc);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = f5;
    r[6:0]   = opc;
    return r;
  endfunction

  // One full transaction: accept, execute, hold response, handshake.
  task automatic do_op(input logic [31:0] ins, input int unsigned hold, input bit clr,
                       input bit force_en, input logic [4:0] force_exc,
                       input bit pend, input logic [31:0] next_ins);
    logic [31:0] o1, o2, o3, exp_res;
    logic [4:0]  exp_exc;
    bit          legal;
    int unsigned lat;
    o1 = $urandom; o2 = $urandom; o3 = $urandom;
    legal = (ins[6:0] == OPC);
    in_valid = 1'b1; in_instr = ins; in_op1 = o1; in_op2 = o2; in_op3 = o3;
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    step;
    in_valid = 1'b0;
    chk("fpu_instr", fpu_instr, ins);
    chk("fpu_op1", fpu_op1, o1);
    chk("fpu_op2", fpu_op2, o2);
    chk("fpu_op3", fpu_op3, o3);
    chk("fpu_start_first", 32'(fpu_start), 32'(legal));
    chk("busy_after_acc", 32'(busy), 32'd1);
    exp_res = 32'h0;
    exp_exc = 5'b10000;
    if (legal) begin
      lat = exp_lat(ins);
      for (int i = 1; i <= int'(lat) + 1; i++) begin
        chk("exec_out_valid", 32'(out_valid), 32'd0);
        chk("exec_in_ready", 32'(in_ready), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
        if (i > 1) chk("exec_fpu_start", 32'(fpu_start), 32'd0);
        fpu_result = $urandom;
        fpu_excep  = force_en ? force_exc : 5'($urandom);
        exp_res = fpu_result;
        exp_exc = fpu_excep;
        step;
      end
    end
    for (int h = 0; h < int'(hold); h++) begin
      if (pend) begin
        in_valid = 1'b1; in_instr = next_ins;
      end
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, exp_res);
      chk("hold_excep", 32'(out_excep), 32'(exp_exc));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      fpu_result = $urandom;
      fpu_excep  = 5'($urandom);
      step;
    end
    if (pend) begin
      in_valid = 1'b1; in_instr = next_ins;
    end
    chk("resp_out_valid", 32'(out_valid), 32'd1);
    chk("resp_result", out_result, exp_res);
    chk("resp_excep", 32'(out_excep), 32'(exp_exc));
    out_ready = 1'b1; fflags_clr = clr;
    step;
    out_ready = 1'b0; fflags_clr = 1'b0;
`ifdef DLFLOAT16_FFLAGS_EN
    m_ff = clr ? exp_exc : (m_ff | exp_exc);
`endif
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_busy", 32'(busy), 32'd0);
    chk("fflags", 32'(fflags), 32'(m_ff));
    if (pend) begin
      chk("no_accept_on_hs", fpu_instr, ins);
      chk("no_start_on_hs", 32'(fpu_start), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ins, nxt;
    logic [4:0]  f5;
    logic [6:0]  opc;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_op1 = '0; in_op2 = '0; in_op3 = '0;
    fpu_result = '0; fpu_excep = '0; out_ready = 1'b0; fflags_clr = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fpu_start", 32'(fpu_start), 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step;

    // Basic add, flags inexact
    do_op(mk_instr(5'b00000, OPC), 0, 1'b0, 1'b1, 5'b00001, 1'b0, 32'h0);
    // Divide and square root
    do_op(mk_instr(5'b00011, OPC), 0, 1'b0, 1'b0, 5'b0, 1'b0, 32'h0);
    do_op(mk_instr(5'b01011, OPC), 1, 1'b0, 1'b0, 5'b0, 1'b0, 32'h0);
    // Illegal opcode
    do_op(mk_instr(5'b00000, 7'h33), 0, 1'b0, 1'b0, 5'b0, 1'b0, 32'h0);
    // Backpressure for 5 cycles with a waiting request, then accept it next edge
    nxt = mk_instr(5'b00001, OPC);
    do_op(mk_instr(5'b00011, OPC), 5, 1'b0, 1'b0, 5'b0, 1'b1, nxt);
    do_op(nxt, 0, 1'b0, 1'b0, 5'b0, 1'b0, 32'h0);

    // Sticky flags sequence
    do_op(mk_instr(5'b00000, OPC), 0, 1'b1, 1'b1, 5'b00001, 1'b0, 32'h0);
    do_op(mk_instr(5'b00000, OPC), 0, 1'b0, 1'b1, 5'b01000, 1'b0, 32'h0);
`ifdef DLFLOAT16_FFLAGS_EN
    chk("fflags_accum", 32'(fflags), 32'h09);
`endif
    do_op(mk_instr(5'b00000, OPC), 0, 1'b1, 1'b1, 5'b00100, 1'b0, 32'h0);
`ifdef DLFLOAT16_FFLAGS_EN
    chk("fflags_clr_hs", 32'(fflags), 32'h04);
`endif

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0: f5 = 5'b00011;
        1: f5 = 5'b01011;
        default: f5 = 5'($urandom);
      endcase
      opc = ($urandom_range(0, 4) == 0) ? 7'($urandom) : OPC;
      ins = mk_instr(f5, opc);
      do_op(ins, $urandom_range(0, 3), $urandom_range(0, 3) == 0, 1'b0, 5'b0, 1'b0, 32'h0);
    end

    // Leave some flags set, then reset mid-EXEC of a divide
    do_op(mk_instr(5'b00000, OPC), 0, 1'b0, 1'b1, 5'b11111, 1'b0, 32'h0);
    in_valid = 1'b1; in_instr = mk_instr(5'b00011, OPC);
    step;
    in_valid = 1'b0;
    step;
    step;
    rst_n = 1'b0;
    #1;
    m_ff = 5'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_fflags", 32'(fflags), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_fpu_instr", fpu_instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step;
      chk("post_rst_no_resp", 32'(out_valid), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
    end
    do_op(mk_instr(5'b00000, OPC), 1, 1'b0, 1'b0, 5'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
